// File: rtl/siso_frame_sequencer.sv
// Valid/ready front end that serializes one parallel word per frame and owns all
// shift timing (strobe, bit count, done pulse, inter-frame gap) for a downstream SISO register.
module siso_frame_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 1,
  parameter int MSB_FIRST  = 1
) (
  input  logic                            Clk_In,
  input  logic                            Reset_In,
  input  logic [DATA_WIDTH-1:0]           Data_In,
  input  logic                            Data_Valid_In,
  output logic                            Data_Ready_Out,
  input  logic                            Abort_In,
  output logic                            Serial_Data_Out,
  output logic                            Shift_Enable_Out,
  output logic                            Frame_Active_Out,
  output logic                            Done_Out,
  output logic [$clog2(DATA_WIDTH+1)-1:0] Bits_Left_Out
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [BW-1:0]         bits_left_q, bits_left_d;
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
  logic                  ser_q, ser_d;
  logic                  shen_q, shen_d;
  logic                  active_q, active_d;
  logic                  done_q, done_d;

  // Bit that goes on the wire next, taken from the transmit end of the word.
  function automatic logic head_bit(input logic [DATA_WIDTH-1:0] w);
    if (MSB_FIRST != 0) begin
      return w[DATA_WIDTH-1];
    end else begin
      return w[0];
    end
  endfunction

  // Word with its head bit consumed; zeros fill in from the far end.
  function automatic logic [DATA_WIDTH-1:0] drop_head(input logic [DATA_WIDTH-1:0] w);
    if (MSB_FIRST != 0) begin
      return {w[DATA_WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, w[DATA_WIDTH-1:1]};
    end
  endfunction

  // Next-state and next-output computation for the frame FSM.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    bits_left_d = bits_left_q;
    gap_cnt_d   = gap_cnt_q;
    ser_d       = ser_q;
    shen_d      = shen_q;
    active_d    = active_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (Data_Valid_In) begin
          state_d     = SHIFT;
          word_d      = drop_head(Data_In);
          ser_d       = head_bit(Data_In);
          shen_d      = 1'b1;
          active_d    = 1'b1;
          bits_left_d = BW'(DATA_WIDTH);
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // Abort or the edge after the last bit: the frame closes either way,
        // but only a clean finish pays the inter-frame gap.
        if (Abort_In || (bits_left_q == BW'(1))) begin
          word_d      = '0;
          ser_d       = 1'b0;
          shen_d      = 1'b0;
          active_d    = 1'b0;
          bits_left_d = '0;
          if (!Abort_In && (GAP_CYCLES > 0)) begin
            state_d   = GAP;
            gap_cnt_d = GW'(GAP_CYCLES);
          end else begin
            state_d   = IDLE;
            gap_cnt_d = '0;
          end
        end else begin
          ser_d       = head_bit(word_q);
          word_d      = drop_head(word_q);
          bits_left_d = bits_left_q - BW'(1);
          done_d      = (bits_left_q == BW'(2));
        end
      end
      GAP: begin
        if (gap_cnt_q <= GW'(1)) begin
          state_d   = IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        word_d      = '0;
        bits_left_d = '0;
        gap_cnt_d   = '0;
        ser_d       = 1'b0;
        shen_d      = 1'b0;
        active_d    = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q     <= IDLE;
      word_q      <= '0;
      bits_left_q <= '0;
      gap_cnt_q   <= '0;
      ser_q       <= 1'b0;
      shen_q      <= 1'b0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      bits_left_q <= bits_left_d;
      gap_cnt_q   <= gap_cnt_d;
      ser_q       <= ser_d;
      shen_q      <= shen_d;
      active_q    <= active_d;
      done_q      <= done_d;
    end
  end

  assign Data_Ready_Out   = (state_q == IDLE) && !Reset_In;
  assign Serial_Data_Out  = ser_q;
  assign Shift_Enable_Out = shen_q;
  assign Frame_Active_Out = active_q;
  assign Done_Out         = done_q;
  assign Bits_Left_Out    = bits_left_q;

endmodule

// File: tb/tb_siso_frame_sequencer.sv
// Directed bench: an MSB-first and an LSB-first sequencer driven in lockstep,
// checked cycle by cycle against hand-derived serial sequences.
module tb_siso_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  logic       abort_in;
  logic       ready_m, ser_m, shen_m, act_m, done_m;
  logic [3:0] bits_m;
  logic       ready_l, ser_l, shen_l, act_l, done_l;
  logic [3:0] bits_l;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  siso_frame_sequencer #(.DATA_WIDTH(8), .GAP_CYCLES(1), .MSB_FIRST(1)) dut (
    .Clk_In(clk), .Reset_In(rst), .Data_In(data), .Data_Valid_In(valid),
    .Data_Ready_Out(ready_m), .Abort_In(abort_in), .Serial_Data_Out(ser_m),
    .Shift_Enable_Out(shen_m), .Frame_Active_Out(act_m), .Done_Out(done_m),
    .Bits_Left_Out(bits_m)
  );

  siso_frame_sequencer #(.DATA_WIDTH(8), .GAP_CYCLES(1), .MSB_FIRST(0)) dut_lsb (
    .Clk_In(clk), .Reset_In(rst), .Data_In(data), .Data_Valid_In(valid),
    .Data_Ready_Out(ready_l), .Abort_In(abort_in), .Serial_Data_Out(ser_l),
    .Shift_Enable_Out(shen_l), .Frame_Active_Out(act_l), .Done_Out(done_l),
    .Bits_Left_Out(bits_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " shen"}, {31'd0, shen_m}, 32'd0);
    check({tag, " active"}, {31'd0, act_m}, 32'd0);
    check({tag, " serial"}, {31'd0, ser_m}, 32'd0);
    check({tag, " done"}, {31'd0, done_m}, 32'd0);
    check({tag, " bits_left"}, {28'd0, bits_m}, 32'd0);
  endtask

  // Called just after the accept edge; walks all 8 bits, the closing edge and the gap.
  // msb_seq/lsb_seq list the expected serial bits in transmit order, first bit leftmost.
  task automatic check_frame(input string tag, input logic [7:0] msb_seq,
                             input logic [7:0] lsb_seq, input int pulse_at);
    for (int k = 0; k < 8; k++) begin
      check({tag, " ser_msb"}, {31'd0, ser_m}, {31'd0, msb_seq[7-k]});
      check({tag, " ser_lsb"}, {31'd0, ser_l}, {31'd0, lsb_seq[7-k]});
      check({tag, " shen"}, {31'd0, shen_m}, 32'd1);
      check({tag, " active"}, {31'd0, act_m}, 32'd1);
      check({tag, " bits_left"}, {28'd0, bits_m}, 32'(8 - k));
      check({tag, " done"}, {31'd0, done_m}, (k == 7) ? 32'd1 : 32'd0);
      check({tag, " ready"}, {31'd0, ready_m}, 32'd0);
      if (k == pulse_at) begin
        data  = 8'hFF;
        valid = 1'b1;
      end else begin
        valid = 1'b0;
      end
      tick();
    end
    valid = 1'b0;
    check_idle_outputs({tag, " end"});
    check({tag, " gap ready"}, {31'd0, ready_m}, 32'd0);
    tick();
    check({tag, " post-gap ready"}, {31'd0, ready_m}, 32'd1);
  endtask

  initial begin
    int cnt;
    rst      = 1'b1;
    data     = 8'h00;
    valid    = 1'b0;
    abort_in = 1'b0;
    tick();
    tick();
    check_idle_outputs("reset");
    check("reset ready", {31'd0, ready_m}, 32'd0);
    rst = 1'b0;
    #1;
    check("ready after release", {31'd0, ready_m}, 32'd1);

    // Frame 8'h0F: MSB-first 00001111, LSB-first 11110000.
    data  = 8'h0F;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    check_frame("f0F", 8'b0000_1111, 8'b1111_0000, -1);

    // Back-to-back A5 then 3C with valid held.
    data  = 8'hA5;
    valid = 1'b1;
    tick();
    data  = 8'h3C;
    check("b2b first bit", {31'd0, ser_m}, 32'd1);
    cnt = 0;
    while (!ready_m && cnt < 20) begin
      cnt++;
      tick();
    end
    check("b2b ready low cycles", 32'(cnt), 32'd9);
    tick();
    valid = 1'b0;
    check("b2b accept spacing", 32'(cnt + 1), 32'd10);
    check_frame("f3C", 8'b0011_1100, 8'b0011_1100, -1);

    // Valid pulsed with FF during an all-zero frame must be ignored.
    data  = 8'h00;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    check_frame("f00", 8'b0000_0000, 8'b0000_0000, 2);
    tick();
    check("no phantom frame", {31'd0, shen_m}, 32'd0);

    // Abort while bit 3 of AA is on the wire.
    data  = 8'hAA;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("abort pre bits_left", {28'd0, bits_m}, 32'(8 - k));
      tick();
    end
    check("abort bit3 serial", {31'd0, ser_m}, 32'd0);
    abort_in = 1'b1;
    tick();
    abort_in = 1'b0;
    check_idle_outputs("abort");
    check("abort ready no gap", {31'd0, ready_m}, 32'd1);
    tick();
    check("abort stays idle", {31'd0, shen_m}, 32'd0);

    // Asynchronous reset mid-frame, then a clean 8'h81 frame.
    data  = 8'h81;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("async reset");
    check("async reset ready", {31'd0, ready_m}, 32'd0);
    tick();
    rst = 1'b0;
    data  = 8'h81;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    check_frame("f81", 8'b1000_0001, 8'b1000_0001, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
